// File: rtl/mac_sequencer.sv
// Operand feeder for one process_unit MAC lane: buffers an activation vector and a weight
// column, then issues (a, b) pairs on a fixed cadence followed by a single finish strobe.
module mac_sequencer #(
    parameter int unsigned N_IN      = 8,
    parameter int unsigned I_WIDTH   = 4,
    parameter int unsigned D_WIDTH   = 16,
    parameter int unsigned ISSUE_GAP = 5
) (
    input  logic               m_clk,
    input  logic               rst,
    input  logic               x_we,
    input  logic [I_WIDTH-1:0] x_addr,
    input  logic [D_WIDTH-1:0] x_data,
    input  logic               w_we,
    input  logic [I_WIDTH-1:0] w_addr,
    input  logic [D_WIDTH-1:0] w_data,
    input  logic [I_WIDTH-1:0] col_index,
    input  logic [I_WIDTH-1:0] vec_len,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fetch_enable,
    output logic [D_WIDTH-1:0] a,
    output logic [D_WIDTH-1:0] b,
    output logic [I_WIDTH-1:0] weight_index,
    output logic               finish_enable
);

    localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned LW = $clog2(N_IN + 1);
    localparam int unsigned GW = $clog2(ISSUE_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_DONE
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               fetch_q;
    logic               finish_q;
    logic [D_WIDTH-1:0] a_q;
    logic [D_WIDTH-1:0] b_q;
    logic [I_WIDTH-1:0] wi_q;
    logic [I_WIDTH-1:0] col_q;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      idx_q;
    logic [GW-1:0]      gap_q;
    logic [LW-1:0]      len_c;

    logic [D_WIDTH-1:0] x_buf_q [N_IN];
    logic [D_WIDTH-1:0] w_buf_q [N_IN];

    // Requested length clamped to the buffer depth.
    always_comb begin
        len_c = LW'(vec_len);
        if (32'(vec_len) > N_IN) begin
            len_c = LW'(N_IN);
        end
    end

    // Operand buffers: writable only between passes, out-of-range addresses dropped.
    always_ff @(posedge m_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                x_buf_q[i] <= '0;
                w_buf_q[i] <= '0;
            end
        end else if (!busy_q) begin
            if (x_we && (32'(x_addr) < N_IN)) begin
                x_buf_q[x_addr[AW-1:0]] <= x_data;
            end
            if (w_we && (32'(w_addr) < N_IN)) begin
                w_buf_q[w_addr[AW-1:0]] <= w_data;
            end
        end
    end

    // Pass sequencer; strobes default low every cycle, operands hold between issues.
    always_ff @(posedge m_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fetch_q  <= 1'b0;
            finish_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            wi_q     <= '0;
            col_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
        end else begin
            fetch_q  <= 1'b0;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // done_q still high means this is the end-of-pass cycle; start is ignored.
                    if (start && !done_q) begin
                        busy_q  <= 1'b1;
                        col_q   <= col_index;
                        len_q   <= len_c;
                        idx_q   <= '0;
                        state_q <= (len_c != '0) ? S_ISSUE : S_FINISH;
                    end
                end
                S_ISSUE: begin
                    fetch_q <= 1'b1;
                    a_q     <= x_buf_q[idx_q[AW-1:0]];
                    b_q     <= w_buf_q[idx_q[AW-1:0]];
                    wi_q    <= col_q;
                    idx_q   <= idx_q + LW'(1);
                    gap_q   <= GW'(ISSUE_GAP - 2);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end else if (idx_q < len_q) begin
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    finish_q <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fetch_enable  = fetch_q;
    assign finish_enable = finish_q;
    assign a             = a_q;
    assign b             = b_q;
    assign weight_index  = wi_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: cycle-exact strobe schedule, operand values, clamping,
// busy-time lockout, asynchronous abort, and a downstream accumulator chained to the outputs.
module tb_mac_sequencer;

    localparam int G = 5;

    logic        m_clk = 1'b0;
    logic        rst;
    logic        x_we, w_we, start;
    logic [3:0]  x_addr, w_addr, col_index, vec_len;
    logic [15:0] x_data, w_data;
    logic        busy, done, fetch_enable, finish_enable;
    logic [15:0] a, b;
    logic [3:0]  weight_index;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] xm [8];
    logic [15:0] wm [8];

    logic [31:0] pe_acc;
    logic [15:0] pe_sum;

    always #5 m_clk = ~m_clk;

    mac_sequencer dut (
        .m_clk         (m_clk),
        .rst           (rst),
        .x_we          (x_we),
        .x_addr        (x_addr),
        .x_data        (x_data),
        .w_we          (w_we),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .col_index     (col_index),
        .vec_len       (vec_len),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fetch_enable  (fetch_enable),
        .a             (a),
        .b             (b),
        .weight_index  (weight_index),
        .finish_enable (finish_enable)
    );

    // Minimal process_unit stand-in: accumulate products, emit upper half on finish.
    always @(posedge m_clk or negedge rst) begin
        if (!rst) begin
            pe_acc <= '0;
            pe_sum <= '0;
        end else begin
            if (fetch_enable) pe_acc <= pe_acc + 32'(a) * 32'(b);
            if (finish_enable) begin
                pe_sum <= pe_acc[31:16];
                pe_acc <= '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit wx, input bit ww, input int addr,
                      input logic [15:0] xd, input logic [15:0] wd);
        @(negedge m_clk);
        x_we = wx; w_we = ww;
        x_addr = 4'(addr); w_addr = 4'(addr);
        x_data = xd; w_data = wd;
        @(negedge m_clk);
        x_we = 1'b0; w_we = 1'b0;
    endtask

    // One pass checked cycle by cycle; poke injects start/write during busy and at done.
    task automatic run_pass(input int vlen, input int col, input bit poke, input string nm);
        int L, last_c, k;
        bit ef, issued;
        logic [15:0] ea, eb;
        logic [3:0] ew;
        L = (vlen > 8) ? 8 : vlen;
        last_c = 2 + L * G;
        issued = 1'b0;
        ea = '0; eb = '0; ew = '0;
        @(negedge m_clk);
        start = 1'b1; vec_len = 4'(vlen); col_index = 4'(col);
        @(negedge m_clk);
        start = 1'b0;
        for (int c = 0; c <= last_c + 1; c++) begin
            ef = (c >= 1) && (((c - 1) % G) == 0) && (((c - 1) / G) < L);
            chk($sformatf("%s c%0d fetch", nm, c), 32'(fetch_enable), 32'(ef));
            chk($sformatf("%s c%0d finish", nm, c), 32'(finish_enable), 32'(c == last_c - 1));
            chk($sformatf("%s c%0d done", nm, c), 32'(done), 32'(c == last_c));
            chk($sformatf("%s c%0d busy", nm, c), 32'(busy), 32'(c < last_c));
            if (ef) begin
                k = (c - 1) / G;
                ea = xm[k]; eb = wm[k]; ew = 4'(col);
                issued = 1'b1;
            end
            if (issued) begin
                chk($sformatf("%s c%0d a", nm, c), 32'(a), 32'(ea));
                chk($sformatf("%s c%0d b", nm, c), 32'(b), 32'(eb));
                chk($sformatf("%s c%0d widx", nm, c), 32'(weight_index), 32'(ew));
            end
            if (poke && c == 10) begin
                start = 1'b1; x_we = 1'b1; x_addr = 4'd0; x_data = 16'hFFFF;
            end
            if (poke && c == 11) begin
                start = 1'b0; x_we = 1'b0;
            end
            if (poke && c == last_c) start = 1'b1;
            if (poke && c == last_c + 1) start = 1'b0;
            @(negedge m_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; x_we = 1'b0; w_we = 1'b0; start = 1'b0;
        x_addr = '0; w_addr = '0; x_data = '0; w_data = '0;
        col_index = '0; vec_len = '0;
        repeat (2) @(negedge m_clk);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst fetch", 32'(fetch_enable), 32'h0);
        chk("rst finish", 32'(finish_enable), 32'h0);
        chk("rst a", 32'(a), 32'h0);
        chk("rst widx", 32'(weight_index), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            xm[i] = 16'(i + 1);
            wm[i] = 16'h0002;
            wr(1'b1, 1'b1, i, xm[i], wm[i]);
        end
        wr(1'b1, 1'b1, 8, 16'hDEAD, 16'hBEEF);

        run_pass(8, 3, 1'b0, "T1");
        run_pass(0, 7, 1'b0, "T2");
        run_pass(12, 1, 1'b0, "T3");
        run_pass(8, 2, 1'b1, "T4");
        run_pass(1, 6, 1'b0, "T4b");

        // Abort a pass at cycle 13 with an asynchronous reset.
        @(negedge m_clk);
        start = 1'b1; vec_len = 4'd8; col_index = 4'd3;
        @(negedge m_clk);
        start = 1'b0;
        repeat (13) @(negedge m_clk);
        chk("T5 pre a", 32'(a), 32'h3);
        chk("T5 pre busy", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("T5 async busy", 32'(busy), 32'h0);
        chk("T5 async a", 32'(a), 32'h0);
        chk("T5 async b", 32'(b), 32'h0);
        chk("T5 async widx", 32'(weight_index), 32'h0);
        chk("T5 async fetch", 32'(fetch_enable), 32'h0);
        chk("T5 async done", 32'(done), 32'h0);
        chk("T5 async finish", 32'(finish_enable), 32'h0);
        @(negedge m_clk);
        rst = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge m_clk);
            chk($sformatf("T5 quiet c%0d", c), 32'({busy, fetch_enable, finish_enable, done}), 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            xm[i] = '0;
            wm[i] = '0;
        end
        run_pass(3, 5, 1'b0, "T5post");

        for (int i = 0; i < 2; i++) begin
            xm[i] = 16'h0100;
            wm[i] = 16'h0200;
            wr(1'b1, 1'b1, i, xm[i], wm[i]);
        end
        run_pass(2, 4, 1'b0, "T6");
        chk("T6 pe_sum", 32'(pe_sum), 32'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
